// File: rtl/digest_reader_pkg.sv
// digest_reader_pkg: shared sizing and state encodings
// for the SHA-256 digest read-out stage.
package digest_reader_pkg;

  localparam int OUTPUT_LENGTH  = 8;
  localparam int WORD_WIDTH     = 32;
  localparam int SYMBOL_WIDTH   = 8;
  localparam int BYTES_PER_WORD = WORD_WIDTH / SYMBOL_WIDTH;

  localparam int ADDR_WIDTH = $clog2(OUTPUT_LENGTH);
  localparam int CNT_WIDTH  = $clog2(BYTES_PER_WORD);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD =
    ADDR_WIDTH'(OUTPUT_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BYTE =
    CNT_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_SEND   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/digest_reader.sv
// digest_reader: reads the digest words out of the output
// SRAM and streams them MSB-first as bytes (valid/ready).
//
// Ports:
//   clock, reset         clock, async active-high reset
//   start                go pulse (H stage finish)
//   op_mem_rdata         SRAM read data (1-cycle latency)
//   regop_op_mem_en/addr SRAM read enable and word address
//   byte_ready           downstream accepts a byte
//   regop_byte_valid/data streamed byte
//   regop_busy           run in progress
//   regop_done           pulse after last byte accepted
module digest_reader
  import digest_reader_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   op_mem_rdata,
  output logic                    regop_op_mem_en,
  output logic [ADDR_WIDTH-1:0]   regop_op_mem_addr,
  input  logic                    byte_ready,
  output logic                    regop_byte_valid,
  output logic [SYMBOL_WIDTH-1:0] regop_byte_data,
  output logic                    regop_busy,
  output logic                    regop_done
);

  state_t r_state;
  state_t w_next;

  logic [WORD_WIDTH-1:0] r_shift;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [CNT_WIDTH-1:0]  r_byte_cnt;

  logic w_accept;
  logic w_last_byte;
  logic w_last_word;

  assign w_accept    = regop_byte_valid && byte_ready;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_last_word = (r_word == LAST_WORD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RD_REQ;
      end
      ST_RD_REQ: w_next = ST_RD_CAP;
      ST_RD_CAP: w_next = ST_SEND;
      ST_SEND: begin
        if (w_accept && w_last_byte) begin
          w_next = w_last_word ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // All outputs are registered; the enable and done pulses
  // default low and are raised only on their transitions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regop_op_mem_en   <= 1'b0;
      regop_op_mem_addr <= '0;
      regop_byte_valid  <= 1'b0;
      regop_byte_data   <= '0;
      regop_busy        <= 1'b0;
      regop_done        <= 1'b0;
      r_shift           <= '0;
      r_word            <= '0;
      r_byte_cnt        <= '0;
    end else begin
      regop_op_mem_en <= 1'b0;
      regop_done      <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            regop_op_mem_en   <= 1'b1;
            regop_op_mem_addr <= '0;
            regop_busy        <= 1'b1;
            r_word            <= '0;
            r_byte_cnt        <= '0;
          end
        end
        ST_RD_REQ: begin
          regop_op_mem_en <= 1'b0;
        end
        ST_RD_CAP: begin
          r_shift          <= op_mem_rdata;
          regop_byte_data  <=
            op_mem_rdata[WORD_WIDTH-1 -: SYMBOL_WIDTH];
          regop_byte_valid <= 1'b1;
          r_byte_cnt       <= '0;
        end
        ST_SEND: begin
          if (w_accept) begin
            if (!w_last_byte) begin
              // Next byte sits just below the one on the bus.
              regop_byte_data <=
                r_shift[WORD_WIDTH-SYMBOL_WIDTH-1 -: SYMBOL_WIDTH];
              r_shift    <= r_shift << SYMBOL_WIDTH;
              r_byte_cnt <= r_byte_cnt + CNT_WIDTH'(1);
            end else begin
              regop_byte_valid <= 1'b0;
              if (!w_last_word) begin
                r_word            <= r_word + ADDR_WIDTH'(1);
                regop_op_mem_addr <= r_word + ADDR_WIDTH'(1);
                regop_op_mem_en   <= 1'b1;
              end else begin
                regop_done <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          regop_busy <= 1'b0;
        end
        default: begin
          regop_byte_valid <= 1'b0;
          regop_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// tb_digest_reader: scoreboard bench for digest_reader
// with a registered-read SRAM model.
module tb_digest_reader;
  import digest_reader_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic [WORD_WIDTH-1:0]   op_mem_rdata = '0;
  logic                    regop_op_mem_en;
  logic [ADDR_WIDTH-1:0]   regop_op_mem_addr;
  logic                    byte_ready = 1'b0;
  logic                    regop_byte_valid;
  logic [SYMBOL_WIDTH-1:0] regop_byte_data;
  logic                    regop_busy;
  logic                    regop_done;

  digest_reader dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .op_mem_rdata      (op_mem_rdata),
    .regop_op_mem_en   (regop_op_mem_en),
    .regop_op_mem_addr (regop_op_mem_addr),
    .byte_ready        (byte_ready),
    .regop_byte_valid  (regop_byte_valid),
    .regop_byte_data   (regop_byte_data),
    .regop_busy        (regop_busy),
    .regop_done        (regop_done)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [OUTPUT_LENGTH];
  logic [31:0] abc [OUTPUT_LENGTH] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  always @(posedge clock)
    if (regop_op_mem_en) op_mem_rdata <= mem[regop_op_mem_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc, n_en, done_cnt, done_edge, first_valid, start_edge;
  bit tog = 0;
  bit prev_busy = 0, prev_done = 0;
  logic [7:0] sb [$];
  logic [ADDR_WIDTH-1:0] aq [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(posedge clock)
    if (tog) begin
      #1 byte_ready = ~byte_ready;
    end

  always @(negedge clock) begin
    if (!reset) begin
      if (regop_byte_valid && first_valid < 0) first_valid = cyc;
      if (regop_byte_valid && byte_ready) begin
        n_acc++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_byte: got %h want none", regop_byte_data);
        end else begin
          chk("byte", {24'd0, regop_byte_data}, {24'd0, sb.pop_front()});
        end
      end
      if (regop_op_mem_en) begin
        n_en++;
        if (aq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_en: got addr %0d want none", regop_op_mem_addr);
        end else begin
          chk("en_addr", 32'(regop_op_mem_addr), 32'(aq.pop_front()));
        end
      end
      if (regop_done) begin
        done_cnt++;
        done_edge = cyc;
        chk("busy_at_done", {31'd0, regop_busy}, 32'd1);
      end
      if (prev_busy && !regop_busy)
        chk("busy_falls_with_done", {31'd0, prev_done}, 32'd1);
      prev_busy = regop_busy;
      prev_done = regop_done;
    end else begin
      prev_busy = 0;
      prev_done = 0;
    end
  end

  task automatic start_run();
    sb.delete();
    aq.delete();
    for (int w = 0; w < OUTPUT_LENGTH; w++) begin
      aq.push_back(ADDR_WIDTH'(w));
      for (int b = 0; b < BYTES_PER_WORD; b++)
        sb.push_back(mem[w][31-8*b -: 8]);
    end
    n_acc = 0; n_en = 0; done_cnt = 0;
    done_edge = -1; first_valid = -1;
    @(posedge clock); #1 start = 1'b1;
    @(negedge clock); start_edge = cyc + 1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done_cnt > 0) break;
    end
    chk({name, "_done_seen"}, 32'(done_cnt), 32'd1);
    repeat (3) @(negedge clock);
  endtask

  task automatic end_checks(string name);
    chk({name, "_bytes"}, 32'(n_acc), 32'd32);
    chk({name, "_en_pulses"}, 32'(n_en), 32'd8);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({name, "_busy_low"}, {31'd0, regop_busy}, 32'd0);
  endtask

  task automatic timing_checks(string name);
    chk({name, "_first_valid"}, 32'(first_valid - start_edge), 32'd2);
    chk({name, "_done_lat"}, 32'(done_edge - start_edge), 32'd48);
  endtask

  initial begin
    for (int i = 0; i < OUTPUT_LENGTH; i++) mem[i] = abc[i];
    repeat (3) @(negedge clock);
    chk("rst_valid", {31'd0, regop_byte_valid}, 32'd0);
    chk("rst_en", {31'd0, regop_op_mem_en}, 32'd0);
    chk("rst_addr", 32'(regop_op_mem_addr), 32'd0);
    chk("rst_busy", {31'd0, regop_busy}, 32'd0);
    chk("rst_done", {31'd0, regop_done}, 32'd0);
    chk("rst_data", {24'd0, regop_byte_data}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    byte_ready = 1'b1;

    // abc digest, ready held high
    start_run();
    wait_done("a");
    end_checks("a");
    timing_checks("a");
    chk("a_addr_hold", 32'(regop_op_mem_addr), 32'd7);

    // stall while byte index 2 is presented
    start_run();
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (regop_byte_valid && n_acc == 2) break;
    end
    chk("b_stall_byte", {24'd0, regop_byte_data}, 32'h16);
    byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("b_hold_data", {24'd0, regop_byte_data}, 32'h16);
      chk("b_hold_valid", {31'd0, regop_byte_valid}, 32'd1);
    end
    @(posedge clock); #1 byte_ready = 1'b1;
    wait_done("b");
    end_checks("b");

    // ready toggling every cycle
    start_run();
    tog = 1;
    wait_done("c");
    tog = 0;
    #2 byte_ready = 1'b1;
    end_checks("c");

    // start re-pulsed mid-stream and in the DONE cycle
    start_run();
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (regop_byte_valid && n_acc == 5) break;
    end
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      if (regop_done) break;
    end
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (6) @(negedge clock);
    end_checks("d");

    // reset while byte index 9 (0x41) is presented
    start_run();
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (regop_byte_valid && n_acc == 9) break;
    end
    chk("e_pre_rst_byte", {24'd0, regop_byte_data}, 32'h41);
    #2 reset = 1'b1;
    #1;
    chk("e_rst_valid", {31'd0, regop_byte_valid}, 32'd0);
    chk("e_rst_en", {31'd0, regop_op_mem_en}, 32'd0);
    chk("e_rst_busy", {31'd0, regop_busy}, 32'd0);
    chk("e_rst_addr", 32'(regop_op_mem_addr), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    start_run();
    wait_done("e");
    end_checks("e");
    timing_checks("e");

    // all-zero digest
    for (int i = 0; i < OUTPUT_LENGTH; i++) mem[i] = '0;
    start_run();
    wait_done("f");
    end_checks("f");
    timing_checks("f");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
